// File: rtl/phase_filter_scheduler_pkg.sv
// Shared constants and types for the phase-current moving-average scheduler.
package phase_filter_scheduler_pkg;

  localparam int N_CH     = 3;
  localparam int DATA_W   = 16;
  localparam int WIN_LOG2 = 2;
  localparam int WIN      = 1 << WIN_LOG2;
  localparam int CH_W     = $clog2(N_CH);
  localparam int SUM_W    = DATA_W + WIN_LOG2;
  localparam int FILL_W   = WIN_LOG2;

  typedef struct packed {
    logic [CH_W-1:0]   channel;
    logic [DATA_W-1:0] data;
    logic              primed;
  } avg_result_t;

  function automatic logic [CH_W-1:0] ch_wrap(input int unsigned v);
    return CH_W'(v % N_CH);
  endfunction

endpackage

// File: rtl/phase_filter_scheduler_if.sv
// Sample-in / average-out bus between the ADC front end, the filter and the trip logic.
interface phase_filter_scheduler_if;
  import phase_filter_scheduler_pkg::*;

  logic [N_CH-1:0]        ch_valid;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic                   filt_enable;
  logic                   clear_hist;
  logic                   avg_valid;
  logic [CH_W-1:0]        avg_channel;
  logic [DATA_W-1:0]      avg_data;
  logic                   avg_primed;
  logic [N_CH-1:0]        overrun;

  modport master (
    output ch_valid, ch_data, filt_enable, clear_hist,
    input  avg_valid, avg_channel, avg_data, avg_primed, overrun
  );

  modport slave (
    input  ch_valid, ch_data, filt_enable, clear_hist,
    output avg_valid, avg_channel, avg_data, avg_primed, overrun
  );

endinterface

// File: rtl/phase_filter_scheduler_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search begins after the last granted channel.
module rr_arbiter
  import phase_filter_scheduler_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_idx,
  output logic            grant_valid
);

  // start_ptr holds the channel after the last grant, so reset to 0 searches channel 0 first.
  logic [CH_W-1:0] start_ptr;
  logic [CH_W-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    if (enable) begin
      for (int k = 0; k < N_CH; k++) begin
        idx = ch_wrap(int'(start_ptr) + k);
        if (!grant_valid && req[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = idx;
          grant[idx]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      start_ptr <= '0;
    end else if (grant_valid) begin
      start_ptr <= ch_wrap(int'(grant_idx) + 1);
    end
  end

endmodule

// File: rtl/phase_filter_scheduler.sv
// Time-shared 4-sample moving average over N_CH ADC channels with per-channel history.
module phase_filter_scheduler
  import phase_filter_scheduler_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  phase_filter_scheduler_if.slave  bus
);

  logic [DATA_W-1:0] pend_data [N_CH];
  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   overrun_q;
  logic [DATA_W-1:0] hist [N_CH][WIN-1];
  logic [FILL_W-1:0] fill [N_CH];

  logic [N_CH-1:0]   grant;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_valid;

  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] avg;
  logic              avg_valid_q;
  avg_result_t       result_q;

  logic              wipe;
  assign wipe = reset || bus.clear_hist;

  rr_arbiter u_arb (
    .clk         (clk),
    .reset       (reset),
    .clear       (bus.clear_hist),
    .enable      (bus.filt_enable),
    .req         (pending),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // A strobe on the channel being granted refills the slot it frees, so it is not an overrun.
  always_ff @(posedge clk) begin
    if (wipe) begin
      pending   <= '0;
      overrun_q <= '0;
      for (int i = 0; i < N_CH; i++) pend_data[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.ch_valid[i] && (!pending[i] || grant[i])) begin
          pending[i]   <= 1'b1;
          pend_data[i] <= bus.ch_data[i*DATA_W +: DATA_W];
        end else if (bus.ch_valid[i]) begin
          overrun_q[i] <= 1'b1;
        end else if (grant[i]) begin
          pending[i]   <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sum = SUM_W'(pend_data[grant_idx]);
    for (int k = 0; k < WIN-1; k++) sum = sum + SUM_W'(hist[grant_idx][k]);
    avg = sum[SUM_W-1:WIN_LOG2];
  end

  always_ff @(posedge clk) begin
    if (wipe) begin
      for (int i = 0; i < N_CH; i++) begin
        fill[i] <= '0;
        for (int k = 0; k < WIN-1; k++) hist[i][k] <= '0;
      end
    end else if (grant_valid) begin
      for (int k = WIN-2; k > 0; k--) hist[grant_idx][k] <= hist[grant_idx][k-1];
      hist[grant_idx][0] <= pend_data[grant_idx];
      if (fill[grant_idx] != FILL_W'(WIN-1)) fill[grant_idx] <= fill[grant_idx] + 1'b1;
    end
  end

  // Result fields hold between strobes; only avg_valid drops back to 0.
  always_ff @(posedge clk) begin
    if (wipe) begin
      avg_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      avg_valid_q <= grant_valid;
      if (grant_valid) begin
        result_q.channel <= grant_idx;
        result_q.data    <= avg;
        result_q.primed  <= (fill[grant_idx] == FILL_W'(WIN-1));
      end
    end
  end

  assign bus.avg_valid   = avg_valid_q;
  assign bus.avg_channel = result_q.channel;
  assign bus.avg_data    = result_q.data;
  assign bus.avg_primed  = result_q.primed;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_phase_filter_scheduler.sv
// Directed vector table plus randomized run against a queue-based behavioural model.
module tb_phase_filter_scheduler;
  import phase_filter_scheduler_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  phase_filter_scheduler_if bus ();

  phase_filter_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  v;
    logic [15:0] d0, d1, d2;
    logic        en, clr;
    logic        ev;
    logic [1:0]  ech;
    logic [15:0] edata;
    logic        eprim;
    logic [2:0]  eover;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: newest history sample at the queue front.
  bit          m_has [N_CH];
  int unsigned m_val [N_CH];
  int unsigned m_hist [N_CH][$];
  int          m_grants [N_CH];
  int          m_next;
  logic [2:0]  m_over;
  logic        e_valid;
  logic [1:0]  e_ch;
  logic [15:0] e_data;
  logic        e_prim;

  function automatic vec_t mk(logic [2:0] v, logic [15:0] d0, logic [15:0] d1, logic [15:0] d2,
                              logic en, logic clr, logic ev, logic [1:0] ech,
                              logic [15:0] edata, logic eprim, logic [2:0] eover);
    vec_t r;
    r.v = v; r.d0 = d0; r.d1 = d1; r.d2 = d2; r.en = en; r.clr = clr;
    r.ev = ev; r.ech = ech; r.edata = edata; r.eprim = eprim; r.eover = eover;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N_CH; i++) begin
      m_has[i] = 0; m_val[i] = 0; m_hist[i].delete(); m_grants[i] = 0;
    end
    m_next = 0; m_over = '0;
    e_valid = 0; e_ch = '0; e_data = '0; e_prim = 0;
  endtask

  task automatic model_step(logic [2:0] v, int unsigned d [N_CH], logic en, logic clr);
    int g;
    int unsigned total;
    if (clr) begin
      model_clear();
      return;
    end
    g = -1;
    if (en) begin
      for (int k = 0; k < N_CH; k++) begin
        if (g < 0 && m_has[(m_next + k) % N_CH]) g = (m_next + k) % N_CH;
      end
    end
    e_valid = (g >= 0);
    if (g >= 0) begin
      total = m_val[g];
      foreach (m_hist[g][j]) total += m_hist[g][j];
      e_ch   = 2'(g);
      e_data = 16'(total / WIN);
      e_prim = (m_grants[g] >= WIN - 1);
      m_hist[g].push_front(m_val[g]);
      if (m_hist[g].size() > WIN - 1) void'(m_hist[g].pop_back());
      m_grants[g]++;
      m_has[g] = 0;
      m_next = (g + 1) % N_CH;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (v[i]) begin
        if (!m_has[i]) begin
          m_has[i] = 1;
          m_val[i] = d[i];
        end else begin
          m_over[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(logic [2:0] v, logic [15:0] d0, logic [15:0] d1, logic [15:0] d2,
                               logic en, logic clr);
    int unsigned d [N_CH];
    @(negedge clk);
    bus.ch_valid    = v;
    bus.ch_data     = {d2, d1, d0};
    bus.filt_enable = en;
    bus.clear_hist  = clr;
    d[0] = d0; d[1] = d1; d[2] = d2;
    model_step(v, d, en, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(string tag, string field, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s %s: got %0h expected %0h", tag, field, got, exp);
    end
  endtask

  task automatic checkOutput(string tag, logic ev, logic [1:0] ech, logic [15:0] edata,
                             logic eprim, logic [2:0] eover, bit chk_data);
    cmp(tag, "avg_valid", 32'(bus.avg_valid), 32'(ev));
    cmp(tag, "overrun", 32'(bus.overrun), 32'(eover));
    if (chk_data) begin
      cmp(tag, "avg_channel", 32'(bus.avg_channel), 32'(ech));
      cmp(tag, "avg_data", 32'(bus.avg_data), 32'(edata));
      cmp(tag, "avg_primed", 32'(bus.avg_primed), 32'(eprim));
    end
  endtask

  initial begin
    // Ramp of four 100s on ch0, five cycles apart
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 0, 0, 16'd0, 0, 3'b000));
    for (int s = 0; s < 4; s++) begin
      vecs.push_back(mk(3'b001, 100, 0, 0, 1, 0, 0, 0, 16'd0, 0, 3'b000));
      vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 1, 0, 16'(25 * (s + 1)), (s == 3), 3'b000));
      for (int j = 0; j < 3; j++) vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 0, 0, 16'd0, 0, 3'b000));
    end
    // Simultaneous strobes on all channels
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 0, 0, 16'd0, 0, 3'b000));
    vecs.push_back(mk(3'b111, 4, 8, 12, 1, 0, 0, 0, 16'd0, 0, 3'b000));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 1, 0, 16'd1, 0, 3'b000));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 1, 1, 16'd2, 0, 3'b000));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 1, 2, 16'd3, 0, 3'b000));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 0, 0, 16'd0, 0, 3'b000));
    // Full-scale samples back to back, then a zero
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 0, 0, 16'd0, 0, 3'b000));
    vecs.push_back(mk(3'b001, 16'hFFFF, 0, 0, 1, 0, 0, 0, 16'd0, 0, 3'b000));
    vecs.push_back(mk(3'b001, 16'hFFFF, 0, 0, 1, 0, 1, 0, 16'h3FFF, 0, 3'b000));
    vecs.push_back(mk(3'b001, 16'hFFFF, 0, 0, 1, 0, 1, 0, 16'h7FFF, 0, 3'b000));
    vecs.push_back(mk(3'b001, 16'hFFFF, 0, 0, 1, 0, 1, 0, 16'hBFFF, 0, 3'b000));
    vecs.push_back(mk(3'b001, 16'h0000, 0, 0, 1, 0, 1, 0, 16'hFFFF, 1, 3'b000));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 1, 0, 16'hBFFF, 1, 3'b000));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 0, 0, 16'd0, 0, 3'b000));
    // Disabled filter: second ch1 strobe overruns
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 0, 0, 16'd0, 0, 3'b000));
    vecs.push_back(mk(3'b010, 0, 10, 0, 0, 0, 0, 0, 16'd0, 0, 3'b000));
    vecs.push_back(mk(3'b010, 0, 20, 0, 0, 0, 0, 0, 16'd0, 0, 3'b010));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 16'd0, 0, 3'b010));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 1, 1, 16'd2, 0, 3'b010));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 0, 0, 16'd0, 0, 3'b010));
    // Clear right after a grant discards the pending sample, overrun and history
    vecs.push_back(mk(3'b001, 200, 0, 0, 1, 0, 0, 0, 16'd0, 0, 3'b010));
    vecs.push_back(mk(3'b001, 300, 0, 0, 1, 0, 1, 0, 16'd50, 0, 3'b010));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 0, 0, 16'd0, 0, 3'b000));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 0, 0, 16'd0, 0, 3'b000));
    vecs.push_back(mk(3'b001, 40, 0, 0, 1, 0, 0, 0, 16'd0, 0, 3'b000));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 1, 0, 16'd10, 0, 3'b000));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 0, 0, 16'd0, 0, 3'b000));
    // ch2 granted in the same cycle a fresh ch2 strobe lands
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 1, 0, 0, 16'd0, 0, 3'b000));
    vecs.push_back(mk(3'b100, 0, 0, 40, 1, 0, 0, 0, 16'd0, 0, 3'b000));
    vecs.push_back(mk(3'b100, 0, 0, 80, 1, 0, 1, 2, 16'd10, 0, 3'b000));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 1, 2, 16'd30, 0, 3'b000));
    vecs.push_back(mk(3'b000, 0, 0, 0, 1, 0, 0, 0, 16'd0, 0, 3'b000));

    bus.ch_valid    = '0;
    bus.ch_data     = '0;
    bus.filt_enable = 1'b0;
    bus.clear_hist  = 1'b0;
    reset           = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < vecs.size(); n++) begin
      applyStimulus(vecs[n].v, vecs[n].d0, vecs[n].d1, vecs[n].d2, vecs[n].en, vecs[n].clr);
      checkOutput($sformatf("vec%0d", n), vecs[n].ev, vecs[n].ech, vecs[n].edata,
                  vecs[n].eprim, vecs[n].eover, vecs[n].ev || vecs[n].clr);
    end

    for (int n = 0; n < 600; n++) begin
      logic [2:0] rv;
      rv[0] = ($urandom_range(0, 99) < 40);
      rv[1] = ($urandom_range(0, 99) < 40);
      rv[2] = ($urandom_range(0, 99) < 40);
      applyStimulus(rv, 16'($urandom), 16'($urandom), 16'($urandom),
                    ($urandom_range(0, 99) < 85), ($urandom_range(0, 63) == 0));
      checkOutput($sformatf("rand%0d", n), e_valid, e_ch, e_data, e_prim, m_over, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
